// File: rtl/noc_axis_packet_tx.sv
// noc_axis_packet_tx: AXI4-Stream packet generator feeding a NoC router adapter; optional counters via NOC_TX_STATS_EN
module noc_axis_packet_tx #(
    parameter int noc_dw  = 512,
    parameter int byte_dw = 8,
    parameter int user_dw = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [byte_dw-1:0]      req_dest,
    input  logic [byte_dw-1:0]      req_id,
    input  logic [7:0]              req_len,
    input  logic [31:0]             req_seed,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [noc_dw-1:0]       m_tdata,
    output logic [noc_dw/byte_dw-1:0] m_tstrb,
    output logic [noc_dw/byte_dw-1:0] m_tkeep,
    output logic [byte_dw-1:0]      m_tid,
    output logic [byte_dw-1:0]      m_tdest,
    output logic [user_dw-1:0]      m_tuser,
    output logic                    m_tlast,
    output logic                    busy,
    output logic [31:0]             stat_pkts,
    output logic [31:0]             stat_flits,
    output logic [31:0]             stat_stall
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [byte_dw-1:0] dest_q, dest_d, id_q, id_d;
    logic [7:0]         len_q, len_d, idx_q, idx_d;
    logic [31:0]        seed_q, seed_d;
    logic [15:0]        seq_q, seq_d;
    logic [31:0]        word;
    logic               hs;

    assign req_ready = state_q == IDLE;
    assign busy      = state_q == SEND;
    assign m_tvalid  = state_q == SEND;
    assign hs        = m_tvalid & m_tready;
    assign word      = seed_q + {24'd0, idx_q};
    assign m_tdata   = m_tvalid ? {(noc_dw/32){word}} : '0;
    assign m_tstrb   = {(noc_dw/byte_dw){m_tvalid}};
    assign m_tkeep   = {(noc_dw/byte_dw){m_tvalid}};
    assign m_tid     = m_tvalid ? id_q : '0;
    assign m_tdest   = m_tvalid ? dest_q : '0;
    assign m_tuser   = m_tvalid ? user_dw'({seq_q, len_q, idx_q}) : '0;
    assign m_tlast   = m_tvalid && idx_q == len_q;

    // Next state: latch a request in IDLE, step the flit index on each handshake, close on the last one
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        id_d    = id_q;
        len_d   = len_q;
        seed_d  = seed_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        if (state_q == IDLE) begin
            if (req_valid) begin
                dest_d  = req_dest;
                id_d    = req_id;
                len_d   = req_len;
                seed_d  = req_seed;
                idx_d   = 8'd0;
                state_d = SEND;
            end
        end else if (hs) begin
            if (m_tlast) begin
                state_d = IDLE;
                seq_d   = seq_q + 16'd1;
            end else begin
                idx_d = idx_q + 8'd1;
            end
        end
    end

    // State and packet context registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dest_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            id_q    <= id_d;
            len_q   <= len_d;
            seed_q  <= seed_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
        end
    end

`ifdef NOC_TX_STATS_EN
    logic [31:0] pkts_q, pkts_d, flits_q, flits_d, stall_q, stall_d;

    // Saturating counters for packets, flits and backpressure cycles
    always_comb begin
        pkts_d  = (hs && m_tlast && ~&pkts_q) ? pkts_q + 32'd1 : pkts_q;
        flits_d = (hs && ~&flits_q) ? flits_q + 32'd1 : flits_q;
        stall_d = (m_tvalid && !m_tready && ~&stall_q) ? stall_q + 32'd1 : stall_q;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pkts_q  <= '0;
            flits_q <= '0;
            stall_q <= '0;
        end else begin
            pkts_q  <= pkts_d;
            flits_q <= flits_d;
            stall_q <= stall_d;
        end
    end

    assign stat_pkts  = pkts_q;
    assign stat_flits = flits_q;
    assign stat_stall = stall_q;
`else
    assign stat_pkts  = '0;
    assign stat_flits = '0;
    assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_noc_axis_packet_tx.sv
// tb_noc_axis_packet_tx: directed self-checking bench for noc_axis_packet_tx (stats expectations follow NOC_TX_STATS_EN)
module tb_noc_axis_packet_tx;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [7:0]   req_dest = '0, req_id = '0, req_len = '0;
    logic [31:0]  req_seed = '0;
    logic         m_tvalid, m_tready = 1'b1, m_tlast, busy;
    logic [511:0] m_tdata;
    logic [63:0]  m_tstrb, m_tkeep;
    logic [7:0]   m_tid, m_tdest;
    logic [31:0]  m_tuser, stat_pkts, stat_flits, stat_stall;
    int tests = 0, fails = 0;

`ifdef NOC_TX_STATS_EN
    localparam bit stats_en = 1'b1;
`else
    localparam bit stats_en = 1'b0;
`endif

    noc_axis_packet_tx dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_id(req_id), .req_len(req_len), .req_seed(req_seed),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
        .m_tkeep(m_tkeep), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .m_tlast(m_tlast), .busy(busy), .stat_pkts(stat_pkts), .stat_flits(stat_flits),
        .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    // Pulse reset for one rising edge; inputs change on falling edges only
    task automatic do_reset();
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Present a request for one edge (DUT is idle), return at the first flit
    task automatic issue(input logic [7:0] dest, input logic [7:0] id, input logic [7:0] len, input logic [31:0] seed);
        req_valid = 1'b1;
        req_dest = dest;
        req_id = id;
        req_len = len;
        req_seed = seed;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({req_ready, busy, m_tvalid, m_tlast} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl got rdy/busy/vld/last=%b want 1000", {req_ready, busy, m_tvalid, m_tlast});
        end
        tests++;
        if (m_tdata !== '0 || m_tuser !== '0 || m_tstrb !== '0 || m_tdest !== '0) begin
            fails++;
            $display("FAIL reset_data got tuser=%h tstrb=%h tdest=%h want zeros", m_tuser, m_tstrb, m_tdest);
        end
        tests++;
        if ({stat_pkts, stat_flits, stat_stall} !== 96'd0) begin
            fails++;
            $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_pkts, stat_flits, stat_stall);
        end
    endtask

    task automatic test_single();
        issue(8'h05, 8'h02, 8'd0, 32'h10);
        tests++;
        if (m_tvalid !== 1'b1 || m_tlast !== 1'b1 || m_tdata !== {16{32'h10}}) begin
            fails++;
            $display("FAIL single_flit got vld=%b last=%b lane0=%h want 1 1 00000010", m_tvalid, m_tlast, m_tdata[31:0]);
        end
        tests++;
        if (m_tuser !== 32'h0 || m_tdest !== 8'h05 || m_tid !== 8'h02 || m_tkeep !== {64{1'b1}} || m_tstrb !== {64{1'b1}}) begin
            fails++;
            $display("FAIL single_side got tuser=%h tdest=%h tid=%h keep=%h want 0 05 02 all-ones", m_tuser, m_tdest, m_tid, m_tkeep);
        end
        @(negedge clk);
        tests++;
        if (m_tvalid !== 1'b0 || req_ready !== 1'b1 || m_tdata !== '0 || m_tid !== '0) begin
            fails++;
            $display("FAIL single_after got vld=%b rdy=%b tid=%h want 0 1 00", m_tvalid, req_ready, m_tid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        issue(8'h11, 8'h22, 8'd3, 32'hFFFFFFFE);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== {16{exp_w[i]}} || m_tlast !== (i == 3)) begin
                fails++;
                $display("FAIL wrap_flit%0d got vld=%b lane0=%h last=%b want 1 %h %b", i, m_tvalid, m_tdata[31:0], m_tlast, exp_w[i], i == 3);
            end
            tests++;
            if (m_tuser !== {16'd1, 8'd3, 8'(i)}) begin
                fails++;
                $display("FAIL wrap_tuser%0d got %h want %h", i, m_tuser, {16'd1, 8'd3, 8'(i)});
            end
            @(negedge clk);
        end
        tests++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL wrap_end got vld=%b want 0", m_tvalid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        issue(8'h07, 8'h03, 8'd2, 32'h100);
        tests++;
        if (m_tdata[31:0] !== 32'h100 || m_tuser[7:0] !== 8'd0) begin
            fails++;
            $display("FAIL stall_f0 got lane0=%h idx=%0d want 00000100 0", m_tdata[31:0], m_tuser[7:0]);
        end
        @(negedge clk);
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (m_tvalid !== 1'b1 || m_tdata !== {16{32'h101}} || m_tuser !== 32'h0000_0201 || m_tlast !== 1'b0 || m_tdest !== 8'h07) begin
                fails++;
                $display("FAIL stall_hold%0d got vld=%b lane0=%h tuser=%h last=%b want 1 00000101 00000201 0", i, m_tvalid, m_tdata[31:0], m_tuser, m_tlast);
            end
        end
        m_tready = 1'b1;
        @(negedge clk);
        tests++;
        if (m_tdata !== {16{32'h102}} || m_tuser !== 32'h0000_0202 || m_tlast !== 1'b1) begin
            fails++;
            $display("FAIL stall_f2 got lane0=%h tuser=%h last=%b want 00000102 00000202 1", m_tdata[31:0], m_tuser, m_tlast);
        end
        @(negedge clk);
        tests++;
        if (m_tvalid !== 1'b0 || stat_stall !== (stats_en ? 32'd5 : 32'd0) || stat_flits !== (stats_en ? 32'd3 : 32'd0) || stat_pkts !== (stats_en ? 32'd1 : 32'd0)) begin
            fails++;
            $display("FAIL stall_stats got vld=%b pkts=%0d flits=%0d stall=%0d want 0 %0d %0d %0d", m_tvalid, stat_pkts, stat_flits, stat_stall, stats_en ? 1 : 0, stats_en ? 3 : 0, stats_en ? 5 : 0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid = 1'b1;
        req_dest = 8'h09;
        req_id = 8'h04;
        req_len = 8'd1;
        req_seed = 32'h20;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (m_tvalid !== 1'b1 || req_ready !== 1'b0 || m_tuser !== {16'(p), 8'd1, 8'(i)} || m_tlast !== (i == 1) || m_tdata[31:0] !== 32'h20 + 32'(i)) begin
                    fails++;
                    $display("FAIL b2b_p%0d_f%0d got vld=%b rdy=%b tuser=%h last=%b lane0=%h want 1 0 %h %b %h", p, i, m_tvalid, req_ready, m_tuser, m_tlast, m_tdata[31:0], {16'(p), 8'd1, 8'(i)}, i == 1, 32'h20 + 32'(i));
                end
                @(negedge clk);
            end
            tests++;
            if (m_tvalid !== 1'b0 || req_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_gap%0d got vld=%b rdy=%b want 0 1", p, m_tvalid, req_ready);
            end
            if (p == 1) req_valid = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (m_tvalid !== 1'b0 || stat_pkts !== (stats_en ? 32'd2 : 32'd0) || stat_flits !== (stats_en ? 32'd4 : 32'd0)) begin
            fails++;
            $display("FAIL b2b_end got vld=%b pkts=%0d flits=%0d", m_tvalid, stat_pkts, stat_flits);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(8'h01, 8'h01, 8'd7, 32'h55);
        @(negedge clk);
        tests++;
        if (m_tvalid !== 1'b1 || m_tuser[7:0] !== 8'd1 || m_tlast !== 1'b0) begin
            fails++;
            $display("FAIL rmid_f1 got vld=%b idx=%0d last=%b want 1 1 0", m_tvalid, m_tuser[7:0], m_tlast);
        end
        reset = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        tests++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rmid_ctrl got vld=%b last=%b rdy=%b busy=%b want 0 0 1 0", m_tvalid, m_tlast, req_ready, busy);
        end
        tests++;
        if ({stat_pkts, stat_flits, stat_stall} !== 96'd0 || m_tdata !== '0) begin
            fails++;
            $display("FAIL rmid_stats got %0d/%0d/%0d want 0/0/0", stat_pkts, stat_flits, stat_stall);
        end
    endtask

    task automatic test_len255();
        do_reset();
        issue(8'hA0, 8'h0B, 8'd255, 32'hABCD0000);
        for (int i = 0; i < 256; i++) begin
            tests++;
            if (m_tvalid !== 1'b1 || m_tuser !== {16'd0, 8'hFF, 8'(i)} || m_tlast !== (i == 255) || m_tdata[511:480] !== 32'hABCD0000 + 32'(i)) begin
                fails++;
                $display("FAIL len255_f%0d got vld=%b tuser=%h last=%b lane15=%h want 1 %h %b %h", i, m_tvalid, m_tuser, m_tlast, m_tdata[511:480], {16'd0, 8'hFF, 8'(i)}, i == 255, 32'hABCD0000 + 32'(i));
            end
            @(negedge clk);
        end
        tests++;
        if (m_tvalid !== 1'b0 || stat_flits !== (stats_en ? 32'd256 : 32'd0) || stat_pkts !== (stats_en ? 32'd1 : 32'd0) || stat_stall !== 32'd0) begin
            fails++;
            $display("FAIL len255_end got vld=%b pkts=%0d flits=%0d stall=%0d", m_tvalid, stat_pkts, stat_flits, stat_stall);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_len255();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/noc_axis_packet_tx.md
NOC_AXIS_PACKET_TX -- requirements
Module: noc_axis_packet_tx

Interface
REQ-001 Parameters SHALL be (name, default, meaning): noc_dw, 512, flit data width; byte_dw, 8, byte width and tid/tdest width; user_dw, 32, tuser width (min 32).
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-003 req_valid in 1 packet request valid; req_ready out 1 request accepted when both high.
REQ-004 req_dest in byte_dw destination; req_id in byte_dw stream id; req_len in 8 flit count minus one; req_seed in 32 payload seed.
REQ-005 m_tvalid out 1; m_tready in 1; m_tdata out noc_dw; m_tstrb out noc_dw/byte_dw; m_tkeep out noc_dw/byte_dw; m_tid out byte_dw; m_tdest out byte_dw; m_tuser out user_dw; m_tlast out 1 -- AXI4-Stream master into the NoC router adapter's slave port.
REQ-006 busy out 1 high while a packet is in progress; stat_pkts out 32, stat_flits out 32, stat_stall out 32 statistics.

Function
REQ-007 FSM SHALL have states IDLE and SEND; reset state IDLE.
REQ-008 req_ready SHALL equal (state==IDLE); busy SHALL equal (state==SEND).
REQ-009 IDLE, req_valid&req_ready: latch dest, id, len, seed; flit index=0; go to SEND; m_tvalid high next cycle (1-cycle request-to-flit latency).
REQ-010 SEND: m_tvalid SHALL stay high; all m_t* outputs SHALL stay stable while m_tvalid&!m_tready.
REQ-011 Flit handshake = m_tvalid&m_tready; on handshake index increments by 1 and next flit is presented the following cycle with no bubble.
REQ-012 m_tdata SHALL be the 32-bit word (seed+index) mod 2^32 replicated across all noc_dw/32 lanes.
REQ-013 m_tstrb and m_tkeep SHALL be all ones while m_tvalid; m_tid=latched id; m_tdest=latched dest.
REQ-014 m_tuser[7:0]=flit index, [15:8]=latched len, [31:16]=packet sequence number (starts 0, +1 per completed packet, wraps 0xFFFF->0); bits above 31 zero.
REQ-015 m_tlast SHALL be high exactly when index==len.
REQ-016 Handshake with m_tlast high: next state IDLE, m_tvalid low next cycle; minimum one idle cycle between packets.
REQ-017 req_len=0 SHALL produce a single flit with m_tlast high.
REQ-018 req_len=255 SHALL produce 256 flits; index SHALL not wrap within a packet.
REQ-019 req_valid during SEND SHALL be ignored (not latched, not lost; held by requester).
REQ-020 When m_tvalid low, m_tdata, m_tstrb, m_tkeep, m_tid, m_tdest, m_tuser, m_tlast SHALL be zero.

Reset
REQ-021 reset sampled on clk rising edge SHALL force state IDLE, m_tvalid=0, all m_t* data outputs 0, req_ready=1 next cycle, busy=0, sequence number 0, statistics 0.
REQ-022 Reset mid-packet SHALL abandon the packet without emitting m_tlast; m_tvalid low the cycle after reset is sampled.
REQ-023 Reset SHALL take priority over any simultaneous request or handshake.

Configuration
REQ-024 Macro NOC_TX_STATS_EN defined: stat_pkts +1 per tlast handshake, stat_flits +1 per flit handshake, stat_stall +1 per cycle with m_tvalid&!m_tready; all saturate at 0xFFFFFFFF.
REQ-025 Macro NOC_TX_STATS_EN undefined: stat ports SHALL exist and be constant 0; no counter logic synthesized.

Verification
REQ-026 Reset, then req len=0 dest=0x05 id=0x02 seed=0x10, m_tready=1 -> one flit next cycle, tdata lanes 0x00000010, tlast=1, tuser=0x00000000, tdest=0x05.
REQ-027 req len=3 seed=0xFFFFFFFE, m_tready=1 -> 4 consecutive flits, lanes 0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001, tlast on 4th only, tuser[15:8]=0x03.
REQ-028 len=2 with m_tready low 5 cycles at 2nd flit -> outputs frozen 5 cycles, no flit dropped/duplicated; stat_stall=5 with NOC_TX_STATS_EN.
REQ-029 Two back-to-back requests held valid -> second accepted one cycle after first tlast handshake; tuser[31:16]=0x0000 then 0x0001.
REQ-030 Assert reset on 2nd flit of a len=7 packet -> m_tvalid low next cycle, req_ready high, no tlast seen, stats 0.
REQ-031 req len=255, m_tready=1 -> exactly 256 flits, tuser[7:0] 0..255, stat_flits=256, stat_pkts=1 with macro; all stats 0 without.
